// File: rtl/sm2_mod_reduce.sv
// Purpose : reduces a 512-bit unsigned product modulo the SM2 prime p = 2^256 - 2^224 - 2^96 + 2^64 - 1.
// Latency : 2..14 cycles from accept to out_valid (up to 10 folds, then up to 2 subtractions).
// Backpr. : one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data (512b) sampled only at the accept edge
//   out_valid/out_ready output handshake; out_data (256b) = in_data mod p, in [0, p-1]
//   busy                high whenever the FSM is not in IDLE
//   lat_cnt (4b)        cycles spent in FOLD+SUB for the current/last operation;
//                       present only when SM2_RED_LAT_CNT_EN is defined
module sm2_mod_reduce (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic         busy
`ifdef SM2_RED_LAT_CNT_EN
    ,
    output logic [3:0]   lat_cnt
`endif
);

    localparam logic [255:0] P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [512:0] P_EXT = {257'd0, P};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [512:0] acc;
    logic [512:0] h_ext;
    logic [512:0] fold_res;
    logic [512:0] sub_res;
    logic         h_zero;
    logic         acc_ge_p;

    // Fold the high part using 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p).
    // The true result is non-negative and below 2^482, so modular 513-bit
    // arithmetic yields it exactly even though the subtraction comes last.
    assign h_ext    = {256'd0, acc[512:256]};
    assign h_zero   = (acc[512:256] == 257'd0);
    assign fold_res = {257'd0, acc[255:0]} + (h_ext << 224) + (h_ext << 96) + h_ext - (h_ext << 64);

    assign acc_ge_p = (acc >= P_EXT);
    assign sub_res  = acc - P_EXT;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = FOLD;
            FOLD: if (h_zero)    state_nxt = SUB;
            SUB:  if (!acc_ge_p) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= {1'b0, in_data};
                    end
                end
                FOLD: begin
                    if (!h_zero) begin
                        acc <= fold_res;
                    end
                end
                SUB: begin
                    if (acc_ge_p) begin
                        acc <= sub_res;
                    end else begin
                        out_data  <= acc[255:0];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SM2_RED_LAT_CNT_EN
    // Counts working cycles only, so it equals the accept-to-out_valid latency
    // and stays frozen while the result waits in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= 4'd0;
        end else if (state == IDLE && in_valid) begin
            lat_cnt <= 4'd0;
        end else if (state == FOLD || state == SUB) begin
            lat_cnt <= lat_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: doc/sm2_mod_reduce.md
SM2_MOD_REDUCE -- requirements
Module: sm2_mod_reduce

Interface
REQ-001 The block SHALL have no parameters; the modulus SHALL be fixed to the SM2 prime p = 2^256 - 2^224 - 2^96 + 2^64 - 1.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block can accept a new product.
REQ-007 in_data  input  512  unsigned product to reduce (e.g. a 256x256 multiplier result).
REQ-008 out_valid  output  1  out_data holds a reduced result.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  256  in_data mod p, always in the range [0, p-1].
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, FOLD, SUB and DONE.
REQ-013 in_ready SHALL equal (state==IDLE); an accept is in_valid & in_ready at a clock edge.
REQ-014 On accept, the block SHALL load a 513-bit accumulator acc with zero-extended in_data and go to FOLD.
REQ-015 FOLD, if acc[512:256] != 0: H = acc[512:256], L = acc[255:0], and acc <= L + H*2^224 + H*2^96 + H - H*2^64; stay in FOLD.
REQ-016 The FOLD result SHALL be computed exactly in 513 bits; it is non-negative by construction, and no truncation is permitted.
REQ-017 FOLD, if acc[512:256] == 0: go to SUB with acc unchanged.
REQ-018 SUB, if acc >= p: acc <= acc - p; stay in SUB.
REQ-019 SUB, if acc < p: out_data <= acc[255:0], out_valid <= 1, go to DONE.
REQ-020 Latency from accept edge to out_valid high SHALL be at least 2 cycles and at most 14 cycles (at most 10 folds and 2 subtractions).
REQ-021 In DONE, out_data and out_valid SHALL be held stable while out_ready is low.
REQ-022 In DONE, if out_ready is high: out_valid <= 0 and go to IDLE; in_ready SHALL be high in the next cycle.
REQ-023 The block SHALL NOT accept a new input while busy; there is no overlap between operations.
REQ-024 in_valid while busy SHALL be ignored; in_data SHALL only be sampled at the accept edge.
REQ-025 out_ready while not in DONE SHALL have no effect.

Reset
REQ-026 rst SHALL force state=IDLE, acc=0, out_data=0, out_valid=0 and busy=0; in_ready SHALL be 1 after reset.
REQ-027 rst asserted in FOLD, SUB or DONE SHALL abort the operation; no out_valid pulse SHALL follow for the aborted input.
REQ-028 rst SHALL take priority over accept and over out_ready in the same cycle.

Configuration
REQ-029 Macro SM2_RED_LAT_CNT_EN defined: the block SHALL add output port lat_cnt [3:0].
REQ-030 lat_cnt SHALL be cleared on accept and incremented each cycle in FOLD or SUB.
REQ-031 lat_cnt SHALL be frozen in DONE and IDLE, and SHALL reset to 0.
REQ-032 Macro undefined: port lat_cnt and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 in_data=0 -> out_data=0, out_valid high 2 cycles after accept.
REQ-034 in_data=p (zero-extended) -> out_data=0 after exactly one subtraction (latency 3).
REQ-035 in_data=2^256 -> out_data=0x00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001.
REQ-036 in_data=(p-1)^2 -> out_data=1; latency <= 14; with the macro defined, lat_cnt equals the measured latency.
REQ-037 Hold out_ready low for 5 cycles in DONE -> out_data stable and in_ready low; then assert rst during FOLD on the next operation -> out_valid stays 0 and in_ready=1 after the reset cycle.
REQ-038 Send 10k random 256x256 products with random out_ready backpressure -> every out_data equals a*b mod p per the golden model, and no input is lost or duplicated.
